// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the APB-programmed PCIe config-request queue:
// register map, bit positions, completion codes, FIFO word layouts, FSM states.
package pcie_cfg_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_IDS      = 8'h04;
  localparam logic [7:0] ADDR_REG_NUM  = 8'h08;
  localparam logic [7:0] ADDR_TX_DATA  = 8'h0C;
  localparam logic [7:0] ADDR_PUSH     = 8'h10;
  localparam logic [7:0] ADDR_STATUS   = 8'h14;
  localparam logic [7:0] ADDR_RSP_DATA = 8'h18;
  localparam logic [7:0] ADDR_RSP_INFO = 8'h1C;

  localparam int CTRL_FMT    = 0;
  localparam int CTRL_TYPE   = 1;
  localparam int CTRL_EN     = 24;
  localparam int CTRL_IRQ_EN = 25;
  localparam int CTRL_FLUSH  = 31;

  localparam int STS_BUSY  = 16;
  localparam int STS_OVF   = 17;
  localparam int STS_TMO   = 18;
  localparam int STS_STRAY = 19;

  localparam logic [2:0] CPL_SC  = 3'b000;
  localparam logic [2:0] CPL_TMO = 3'b001;

  // Queued request: staged fields plus the tag assigned at push time.
  typedef struct packed {
    logic        fmt;
    logic        typ;
    logic [3:0]  fbe;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [15:0] des_id;
    logic [9:0]  reg_num;
    logic [31:0] tx_data;
  } cmd_t;

  // Returned result: {rx_data, status, tag, timeout}.
  typedef struct packed {
    logic [31:0] rx_data;
    logic [2:0]  status;
    logic [7:0]  tag;
    logic        timeout;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Byte-lane merge of an APB write into an existing 32-bit register.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pcie_cfg_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pcie_cfg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pcie_cfg_req_queue_apb.sv
// APB-programmed PCIe config-request engine: queues requests with auto tags,
// issues them one at a time, matches completions by tag, times out silent ones.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | nothing in flight; issue when enabled, cmd queued, rsp slot free
//   ST_ISSUE | req_valid high with head-of-queue fields, waiting for req_ready
//   ST_WAIT  | request accepted; waiting for matching completion or timeout
module pcie_cfg_req_queue_apb
  import pcie_cfg_pkg::*;
#(
  parameter int         QDEPTH      = 4,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] TAG_BASE    = 8'h00
) (
  input  logic        pclk_div2,
  input  logic        apb_rst_n,
  input  logic        p_sel,
  input  logic        p_ce,
  input  logic        p_we,
  input  logic [3:0]  p_strb,
  input  logic [7:0]  p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_rdy,
  output logic [31:0] p_rdata,
  output logic        irq,
  output logic        pcie_cfg_ctrl_en,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_fmt,
  output logic        req_type,
  output logic [3:0]  req_fbe,
  output logic [7:0]  req_tag,
  output logic [15:0] req_req_id,
  output logic [15:0] req_des_id,
  output logic [9:0]  req_reg_num,
  output logic [31:0] req_tx_data,
  input  logic        cpl_rcv,
  input  logic [7:0]  cpl_tag,
  input  logic [2:0]  cpl_status,
  input  logic [31:0] cpl_rx_data
);
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam int            CW       = $clog2(QDEPTH) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    inflight_tag_q, inflight_tag_d;
  logic [7:0]    tag_cnt_q, tag_cnt_d;
  logic          p_rdy_q, p_rdy_d;
  logic          fmt_q, fmt_d, typ_q, typ_d, ctrl_en_q, ctrl_en_d, irq_en_q, irq_en_d;
  logic [3:0]    fbe_q, fbe_d;
  logic [15:0]   req_id_q, req_id_d, des_id_q, des_id_d;
  logic [9:0]    reg_num_q, reg_num_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          ovf_q, ovf_d, tmo_q, tmo_d, stray_q, stray_d;

  logic          wr_en, rd_en, flush, sts_w1c;
  logic          cmd_push, cmd_acc, cmd_pop, cmd_full, cmd_empty;
  logic          rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic          stray_set, tmo_set;
  logic [CW-1:0] cmd_cnt, rsp_cnt;
  cmd_t          cmd_din, cmd_head;
  rsp_t          rsp_din, rsp_head;
  logic [31:0]   rd_mux, reg_num_wr, ids_wr;

  assign wr_en    = p_ce & p_we & p_rdy_q;
  assign rd_en    = p_ce & ~p_we & p_rdy_q;
  assign flush    = wr_en & (p_addr == ADDR_CTRL) & p_strb[3] & p_wdata[CTRL_FLUSH];
  assign sts_w1c  = wr_en & (p_addr == ADDR_STATUS) & p_strb[2];
  assign cmd_push = wr_en & (p_addr == ADDR_PUSH) & p_strb[0] & p_wdata[0] & ~flush;
  assign cmd_acc  = cmd_push & (~cmd_full | cmd_pop);
  assign rsp_pop  = rd_en & (p_addr == ADDR_RSP_DATA);
  assign cmd_din  = '{fmt: fmt_q, typ: typ_q, fbe: fbe_q, tag: tag_cnt_q, req_id: req_id_q,
                      des_id: des_id_q, reg_num: reg_num_q, tx_data: tx_data_q};

  pcie_cfg_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(QDEPTH)) u_cmd_fifo (
    .clk(pclk_div2), .rst_n(apb_rst_n), .clr(flush), .push(cmd_push), .din(cmd_din),
    .pop(cmd_pop), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_cnt)
  );

  pcie_cfg_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(QDEPTH)) u_rsp_fifo (
    .clk(pclk_div2), .rst_n(apb_rst_n), .clr(flush), .push(rsp_push), .din(rsp_din),
    .pop(rsp_pop), .dout(rsp_head), .full(rsp_full), .empty(rsp_empty), .count(rsp_cnt)
  );

  // Issue FSM: next state, FIFO handshakes, timeout counter, stray/timeout events.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    inflight_tag_d = inflight_tag_q;
    cmd_pop        = 1'b0;
    rsp_push       = 1'b0;
    rsp_din        = '0;
    stray_set      = 1'b0;
    tmo_set        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stray_set = cpl_rcv;
        if (ctrl_en_q && !cmd_empty && !rsp_full) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        stray_set = cpl_rcv;
        if (req_ready) begin
          cmd_pop        = 1'b1;
          inflight_tag_d = cmd_head.tag;
          timer_d        = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpl_rcv && (cpl_tag == inflight_tag_q)) begin
          rsp_push = 1'b1;
          rsp_din  = '{rx_data: cpl_rx_data, status: cpl_status, tag: inflight_tag_q, timeout: 1'b0};
          state_d  = ST_IDLE;
        end else begin
          stray_set = cpl_rcv;
          if (timer_q == TMO_LAST) begin
            rsp_push = 1'b1;
            rsp_din  = '{rx_data: 32'hFFFF_FFFF, status: CPL_TMO, tag: inflight_tag_q, timeout: 1'b1};
            tmo_set  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // APB register writes, tag counter and sticky status flags (set beats W1C).
  always_comb begin
    p_rdy_d    = p_sel & ~p_ce;
    fmt_d      = fmt_q;
    typ_d      = typ_q;
    fbe_d      = fbe_q;
    ctrl_en_d  = ctrl_en_q;
    irq_en_d   = irq_en_q;
    ids_wr     = apply_strb({des_id_q, req_id_q}, p_wdata, p_strb);
    reg_num_wr = apply_strb({22'b0, reg_num_q}, p_wdata, p_strb);
    req_id_d   = req_id_q;
    des_id_d   = des_id_q;
    reg_num_d  = reg_num_q;
    tx_data_d  = tx_data_q;
    tag_cnt_d  = cmd_acc ? tag_cnt_q + 8'd1 : tag_cnt_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    stray_d    = stray_q;
    if (wr_en) begin
      unique case (p_addr)
        ADDR_CTRL: begin
          if (p_strb[0]) begin
            fmt_d = p_wdata[CTRL_FMT];
            typ_d = p_wdata[CTRL_TYPE];
            fbe_d = p_wdata[5:2];
          end
          if (p_strb[3]) begin
            ctrl_en_d = p_wdata[CTRL_EN];
            irq_en_d  = p_wdata[CTRL_IRQ_EN];
          end
        end
        ADDR_IDS: begin
          req_id_d = ids_wr[15:0];
          des_id_d = ids_wr[31:16];
        end
        ADDR_REG_NUM: reg_num_d = reg_num_wr[9:0];
        ADDR_TX_DATA: tx_data_d = apply_strb(tx_data_q, p_wdata, p_strb);
        default: ;
      endcase
    end
    if (sts_w1c) begin
      if (p_wdata[STS_OVF])   ovf_d   = 1'b0;
      if (p_wdata[STS_TMO])   tmo_d   = 1'b0;
      if (p_wdata[STS_STRAY]) stray_d = 1'b0;
    end
    if (cmd_push && !cmd_acc) ovf_d = 1'b1;
    if (tmo_set)   tmo_d   = 1'b1;
    if (stray_set) stray_d = 1'b1;
  end

  // Read data selection for the current access-phase address.
  always_comb begin
    rd_mux = '0;
    unique case (p_addr)
      ADDR_CTRL:     rd_mux = {6'b0, irq_en_q, ctrl_en_q, 18'b0, fbe_q, typ_q, fmt_q};
      ADDR_IDS:      rd_mux = {des_id_q, req_id_q};
      ADDR_REG_NUM:  rd_mux = {22'b0, reg_num_q};
      ADDR_TX_DATA:  rd_mux = tx_data_q;
      ADDR_STATUS:   rd_mux = {12'b0, stray_q, tmo_q, ovf_q, (state_q != ST_IDLE),
                               3'b0, 5'(rsp_cnt), 3'b0, 5'(cmd_cnt)};
      ADDR_RSP_DATA: rd_mux = rsp_empty ? 32'h0 : rsp_head.rx_data;
      ADDR_RSP_INFO: rd_mux = rsp_empty ? 32'h0 :
                              {1'b1, 19'b0, rsp_head.timeout, rsp_head.status, rsp_head.tag};
      default:       rd_mux = '0;
    endcase
  end

  // All control and configuration flops.
  always_ff @(posedge pclk_div2) begin
    if (!apb_rst_n) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      inflight_tag_q <= '0;
      tag_cnt_q      <= TAG_BASE;
      p_rdy_q        <= 1'b0;
      fmt_q          <= 1'b0;
      typ_q          <= 1'b0;
      fbe_q          <= '0;
      ctrl_en_q      <= 1'b0;
      irq_en_q       <= 1'b0;
      req_id_q       <= '0;
      des_id_q       <= '0;
      reg_num_q      <= '0;
      tx_data_q      <= '0;
      ovf_q          <= 1'b0;
      tmo_q          <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      inflight_tag_q <= inflight_tag_d;
      tag_cnt_q      <= tag_cnt_d;
      p_rdy_q        <= p_rdy_d;
      fmt_q          <= fmt_d;
      typ_q          <= typ_d;
      fbe_q          <= fbe_d;
      ctrl_en_q      <= ctrl_en_d;
      irq_en_q       <= irq_en_d;
      req_id_q       <= req_id_d;
      des_id_q       <= des_id_d;
      reg_num_q      <= reg_num_d;
      tx_data_q      <= tx_data_d;
      ovf_q          <= ovf_d;
      tmo_q          <= tmo_d;
      stray_q        <= stray_d;
    end
  end

  assign p_rdy            = p_rdy_q;
  assign p_rdata          = (p_rdy_q & ~p_we) ? rd_mux : 32'h0;
  assign irq              = irq_en_q & ~rsp_empty;
  assign pcie_cfg_ctrl_en = ctrl_en_q;
  assign req_valid        = (state_q == ST_ISSUE);
  assign req_fmt          = req_valid & cmd_head.fmt;
  assign req_type         = req_valid & cmd_head.typ;
  assign req_fbe          = req_valid ? cmd_head.fbe     : '0;
  assign req_tag          = req_valid ? cmd_head.tag     : '0;
  assign req_req_id       = req_valid ? cmd_head.req_id  : '0;
  assign req_des_id       = req_valid ? cmd_head.des_id  : '0;
  assign req_reg_num      = req_valid ? cmd_head.reg_num : '0;
  assign req_tx_data      = req_valid ? cmd_head.tx_data : '0;

endmodule

// File: tb/tb_pcie_cfg_req_queue_apb.sv
// Directed bench: QDEPTH=4, TIMEOUT_CYC=16, TAG_BASE=FE so tag wrap is exercised
// along the main request/completion flow.
module tb_pcie_cfg_req_queue_apb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_sel = 1'b0, p_ce = 1'b0, p_we = 1'b0;
  logic [3:0]  p_strb = 4'h0;
  logic [7:0]  p_addr = 8'h00;
  logic [31:0] p_wdata = 32'h0;
  logic        p_rdy;
  logic [31:0] p_rdata;
  logic        irq, ctrl_en_o, req_valid;
  logic        req_ready = 1'b0;
  logic        req_fmt, req_type;
  logic [3:0]  req_fbe;
  logic [7:0]  req_tag;
  logic [15:0] req_req_id, req_des_id;
  logic [9:0]  req_reg_num;
  logic [31:0] req_tx_data;
  logic        cpl_rcv = 1'b0;
  logic [7:0]  cpl_tag = 8'h00;
  logic [2:0]  cpl_status = 3'b000;
  logic [31:0] cpl_rx_data = 32'h0;

  int errors = 0;
  int checks = 0;

  pcie_cfg_req_queue_apb #(.QDEPTH(4), .TIMEOUT_CYC(16), .TAG_BASE(8'hFE)) dut (
    .pclk_div2(clk), .apb_rst_n(rst_n),
    .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_strb(p_strb), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdy(p_rdy), .p_rdata(p_rdata),
    .irq(irq), .pcie_cfg_ctrl_en(ctrl_en_o),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_type(req_type), .req_fbe(req_fbe), .req_tag(req_tag),
    .req_req_id(req_req_id), .req_des_id(req_des_id), .req_reg_num(req_reg_num),
    .req_tx_data(req_tx_data),
    .cpl_rcv(cpl_rcv), .cpl_tag(cpl_tag), .cpl_status(cpl_status), .cpl_rx_data(cpl_rx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    p_sel = 1'b1; p_ce = 1'b0; p_we = 1'b1; p_addr = addr; p_wdata = data; p_strb = strb;
    tick();
    p_ce = 1'b1;
    tick();
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = 4'h0;
  endtask

  task automatic apb_rd(input logic [7:0] addr, output logic [31:0] data);
    p_sel = 1'b1; p_ce = 1'b0; p_we = 1'b0; p_addr = addr;
    tick();
    p_ce = 1'b1;
    #1;
    data = p_rdata;
    tick();
    p_sel = 1'b0; p_ce = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(addr, d);
    chk(name, d, exp);
  endtask

  task automatic wait_req(input string name, input logic [7:0] exp_tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 32'(req_valid), 32'd1);
    chk({name, "_tag"}, 32'(req_tag), 32'(exp_tag));
  endtask

  task automatic accept();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic send_cpl(input logic [7:0] tag, input logic [2:0] st, input logic [31:0] data);
    cpl_rcv = 1'b1; cpl_tag = tag; cpl_status = st; cpl_rx_data = data;
    tick();
    cpl_rcv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok;
    logic [31:0] d;

    tick(); tick();
    rst_n = 1'b1;
    tick();
    // reset state
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_p_rdy", 32'(p_rdy), 32'd0);
    rd_chk("rst_status", 8'h14, 32'h0000_0000);
    rd_chk("rst_ctrl", 8'h00, 32'h0000_0000);

    // stage fbe=F, des_id=0100, reg=0, tx_data; five pushes with QDEPTH=4
    apb_wr(8'h00, 32'h0000_003C, 4'hF);
    apb_wr(8'h04, 32'h0100_0000, 4'hF);
    apb_wr(8'h08, 32'h0000_0000, 4'hF);
    apb_wr(8'h0C, 32'hA5A5_0001, 4'hF);
    for (int i = 0; i < 5; i++) apb_wr(8'h10, 32'h1, 4'h1);
    rd_chk("ovf_status", 8'h14, 32'h0002_0004);
    rd_chk("ctrl_rb", 8'h00, 32'h0000_003C);
    rd_chk("ids_rb", 8'h04, 32'h0100_0000);
    apb_wr(8'h14, 32'h0002_0000, 4'b0100);
    rd_chk("ovf_w1c", 8'h14, 32'h0000_0004);

    // enable with irq; first issue carries FE, held for 10 cycles
    apb_wr(8'h00, 32'h0300_003C, 4'hF);
    chk("ctrl_en_out", 32'(ctrl_en_o), 32'd1);
    wait_req("iss0", 8'hFE);
    chk("iss0_fbe", 32'(req_fbe), 32'hF);
    chk("iss0_des_id", 32'(req_des_id), 32'h0100);
    chk("iss0_tx_data", req_tx_data, 32'hA5A5_0001);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!req_valid || req_tag != 8'hFE || req_tx_data != 32'hA5A5_0001) hold_ok = 1'b0;
      tick();
    end
    chk("hold_stable", 32'(hold_ok), 32'd1);
    accept();
    rd_chk("wait_status", 8'h14, 32'h0001_0003);
    send_cpl(8'hFE, 3'b000, 32'h10EE_1234);
    chk("irq_set", 32'(irq), 32'd1);
    rd_chk("rsp0_info", 8'h1C, 32'h8000_00FE);
    rd_chk("rsp0_data", 8'h18, 32'h10EE_1234);
    chk("irq_clr", 32'(irq), 32'd0);

    // tag wrap FF -> 00, stray completion while waiting on 00
    wait_req("iss1", 8'hFF);
    accept();
    send_cpl(8'hFF, 3'b000, 32'h1111_2222);
    wait_req("iss2", 8'h00);
    accept();
    send_cpl(8'h07, 3'b000, 32'hDEAD_BEEF);
    rd_chk("stray_status", 8'h14, 32'h0009_0101);
    send_cpl(8'h00, 3'b010, 32'h2222_3333);
    apb_wr(8'h14, 32'h0008_0000, 4'b0100);
    rd_chk("stray_w1c", 8'h14, 32'h0001_0201);
    rd_chk("rsp1_info", 8'h1C, 32'h8000_00FF);
    rd_chk("rsp1_data", 8'h18, 32'h1111_2222);
    rd_chk("rsp2_info", 8'h1C, 32'h8000_0200);
    rd_chk("rsp2_data", 8'h18, 32'h2222_3333);
    rd_chk("rsp_empty_data", 8'h18, 32'h0000_0000);

    // tag 01 never answered: timeout after exactly 16 WAIT cycles
    wait_req("iss3", 8'h01);
    accept();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_early", 32'(irq), 32'd0);
    tick();
    chk("tmo_irq", 32'(irq), 32'd1);
    rd_chk("tmo_info", 8'h1C, 32'h8000_0901);
    rd_chk("tmo_data", 8'h18, 32'hFFFF_FFFF);
    rd_chk("tmo_status", 8'h14, 32'h0004_0000);

    // flush mid-WAIT with one queued; late completion becomes stray
    apb_wr(8'h10, 32'h1, 4'h1);
    wait_req("iss4", 8'h02);
    accept();
    apb_wr(8'h10, 32'h1, 4'h1);
    apb_wr(8'h00, 32'h8300_003C, 4'hF);
    chk("flush_req_valid", 32'(req_valid), 32'd0);
    rd_chk("flush_status", 8'h14, 32'h0004_0000);
    send_cpl(8'h02, 3'b000, 32'h0BAD_0BAD);
    rd_chk("late_cpl_stray", 8'h14, 32'h000C_0000);
    apb_wr(8'h14, 32'h000E_0000, 4'b0100);
    rd_chk("w1c_all", 8'h14, 32'h0000_0000);
    apb_wr(8'h10, 32'h1, 4'h1);
    wait_req("iss5_tag_kept", 8'h04);

    // reset while in ISSUE
    rst_n = 1'b0;
    tick();
    chk("rst_mid_req_valid", 32'(req_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_ctrl_en", 32'(ctrl_en_o), 32'd0);
    rd_chk("rst_mid_status", 8'h14, 32'h0000_0000);
    apb_wr(8'h00, 32'h0100_0000, 4'hF);
    apb_wr(8'h10, 32'h1, 4'h1);
    wait_req("iss6_after_rst", 8'hFE);
    chk("iss6_fbe", 32'(req_fbe), 32'h0);
    d = req_tx_data;
    chk("iss6_tx_data", d, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
